// File: rtl/serial_add_unit.sv
// Bit-serial adder: one full-adder cell plus a carry flop computes a + b + cin
// LSB first over WIDTH cycles, with a start/done handshake.
module serial_add_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bit_s, bit_c;

  always_comb begin
    bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    bit_c    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {bit_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = bit_c;
        cnt_d    = cnt_q + CntW'(1);
        // Outputs only change here, so partial sums never reach the port.
        if (cnt_q == LastCnt) begin
          sum_d   = {bit_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = bit_c;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit (WIDTH=4): vector table plus hand-built
// sequences for reset, mid-run start, back-to-back and abort cases.
module tb_serial_add_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_vec = 0;
  int n_err = 0;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single op from IDLE; operands are scrambled after acceptance.
  task automatic run_op(input vec_t v, input string name);
    int lat;
    a = v.va; b = v.vb; cin = v.vcin; start = 1'b1;
    tick;
    start = 1'b0; a = ~v.va; b = ~v.vb; cin = ~v.vcin;
    chk({name, "_busy"}, {31'b0, busy}, 32'd1);
    lat = 0;
    for (int i = 0; i < 3 * W && !done; i++) begin
      tick;
      lat++;
      chk({name, "_excl"}, {31'b0, busy & done}, 32'd0);
    end
    chk({name, "_lat"}, lat, W);
    chk({name, "_sum"}, {28'b0, sum}, {28'b0, v.esum});
    chk({name, "_cout"}, {31'b0, cout}, {31'b0, v.ecout});
    tick;
    chk({name, "_pulse"}, {30'b0, done, busy}, 32'd0);
    chk({name, "_hold"}, {27'b0, cout, sum}, {27'b0, v.ecout, v.esum});
  endtask

  initial begin
    vec_t vt[9];
    bit   saw_done;
    // Last four rows: subtractor X-Y-Bin=Diff,Bout fed back as Diff+Y+Bin;
    // expect sum==X and cout==Bout (the borrow reappears as the carry).
    vt[0] = '{4'b0001, 4'b1101, 1'b0, 4'b1110, 1'b0};
    vt[1] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vt[2] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[3] = '{4'b1100, 4'b0011, 1'b1, 4'b0000, 1'b1};
    vt[4] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
    vt[5] = '{4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0};
    vt[6] = '{4'b1110, 4'b0101, 1'b0, 4'b0011, 1'b1};
    vt[7] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
    vt[8] = '{4'b0100, 4'b0100, 1'b1, 4'b1001, 1'b0};

    // Reset held two cycles with start asserted.
    rst = 1'b1; start = 1'b1; a = 4'b1111; b = 4'b1111; cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("reset_state", {25'b0, busy, done, cout, sum}, 32'd0);
    end
    rst = 1'b0; start = 1'b0;
    tick;
    chk("reset_idle", {30'b0, busy, done}, 32'd0);

    foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));

    // Start re-pulsed mid-run with different operands must be ignored.
    a = 4'b1100; b = 4'b0011; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    a = 4'b0101; b = 4'b0101; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("midrun_busy", {30'b0, busy, done}, 32'd2);
    tick;
    chk("midrun_done", {31'b0, done}, 32'd1);
    chk("midrun_res", {27'b0, cout, sum}, {27'b0, 1'b1, 4'b0000});
    tick;

    // Start held high: back-to-back ops, done pulses 5 cycles apart.
    a = 4'b1000; b = 4'b0111; cin = 1'b0; start = 1'b1;
    tick;
    a = 4'b0110; b = 4'b0001;
    repeat (3) tick;
    chk("b2b_early", {31'b0, done}, 32'd0);
    tick;
    chk("b2b_done1", {31'b0, done}, 32'd1);
    chk("b2b_res1", {27'b0, cout, sum}, {27'b0, 1'b0, 4'b1111});
    tick;
    start = 1'b0;
    chk("b2b_rerun", {30'b0, busy, done}, 32'd2);
    repeat (3) tick;
    chk("b2b_held", {26'b0, done, cout, sum}, {26'b0, 2'b00, 4'b1111});
    tick;
    chk("b2b_done2", {31'b0, done}, 32'd1);
    chk("b2b_res2", {27'b0, cout, sum}, {27'b0, 1'b0, 4'b0111});
    tick;
    chk("b2b_idle", {25'b0, busy, done, cout, sum}, {25'b0, 3'b000, 4'b0111});

    // Reset in the middle of a run aborts it.
    a = 4'b0011; b = 4'b0001; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_state", {25'b0, busy, done, cout, sum}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done) saw_done = 1'b1;
    end
    chk("abort_nodone", {31'b0, saw_done}, 32'd0);
    run_op('{4'b0101, 4'b0110, 1'b1, 4'b1100, 1'b0}, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
